// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline sequencing controller for the 5-stage core. Works next to the
// forwarding unit: whatever forwarding cannot resolve (load-use, store-data,
// taken branches, slow data memory) is handled here by stalling, flushing or
// bubbling pipeline registers.
//
// Parameters
//   LOAD_LAT : data-memory load latency in stall cycles (1..7)
//   CNT_W    : width of the stall / flush performance counters
//
// Ports
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   IF_ID_RN1/RN2       : source registers of the instruction in ID
//   IF_ID_UsesRN2       : ID instruction actually reads RN2
//   ID_EX_MR, ID_EX_WN  : EX instruction is a load / its destination reg
//   StoreHazard         : store-data hazard flag from the forwarding unit
//   BranchTaken         : branch resolved taken in EX
//   MemReq, MemReady    : MEM-stage access valid / data memory completes
//   PC_En .. EX_MEM_En  : pipeline register enables
//   IF_ID_Flush,
//   ID_EX_Flush         : load NOP into IF/ID, ID/EX
//   EX_MEM_Bubble,
//   MEM_WB_Bubble       : load NOP into EX/MEM, MEM/WB
//   State               : FSM state for debug
//   StallCount          : saturating count of cycles with PC_En=0
//   FlushCount          : saturating count of branch flush events
// -----------------------------------------------------------------------------
module hazard_control_unit #(
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       IF_ID_RN1,
   input  logic [3:0]       IF_ID_RN2,
   input  logic             IF_ID_UsesRN2,
   input  logic             ID_EX_MR,
   input  logic [3:0]       ID_EX_WN,
   input  logic             StoreHazard,
   input  logic             BranchTaken,
   input  logic             MemReq,
   input  logic             MemReady,
   output logic             PC_En,
   output logic             IF_ID_En,
   output logic             ID_EX_En,
   output logic             EX_MEM_En,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Bubble,
   output logic             MEM_WB_Bubble,
   output logic [2:0]       State,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   typedef enum logic [2:0] {
      ST_RUN         = 3'd0,
      ST_LOAD_STALL  = 3'd1,
      ST_STORE_STALL = 3'd2,
      ST_MEM_WAIT    = 3'd3,
      ST_FLUSH       = 3'd4
   } state_e;

   // Remaining stall cycles after the detection cycle of a load-use hazard.
   localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

   // Counters stick at all-ones so a long run never wraps to a small value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic mem_wait;
   logic load_use;
   logic flush_evt;

   logic pc_en, ifid_en, idex_en, exmem_en;
   logic ifid_flush, idex_flush, exmem_bubble, memwb_bubble;

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   assign mem_wait = MemReq & ~MemReady;

   // r0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = ID_EX_MR & (ID_EX_WN != 4'd0) &
                     ((IF_ID_RN1 == ID_EX_WN) |
                      (IF_ID_UsesRN2 & (IF_ID_RN2 == ID_EX_WN)));

   // ------------------------------------------------------------------------
   // Next state and Mealy outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = ST_RUN;
      cnt_d        = cnt_q;
      flush_evt    = 1'b0;
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_bubble = 1'b0;
      memwb_bubble = 1'b0;

      if (mem_wait) begin
         // Freeze everything up to EX/MEM; the load counter keeps its value so
         // an interrupted load stall resumes where it left off.
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
         state_d      = ST_MEM_WAIT;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (BranchTaken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  flush_evt  = 1'b1;
                  state_d    = ST_FLUSH;
               end else if (load_use) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
                  cnt_d      = LAT_M1;
                  state_d    = (LOAD_LAT == 1) ? ST_RUN : ST_LOAD_STALL;
               end else if (StoreHazard) begin
                  pc_en        = 1'b0;
                  ifid_en      = 1'b0;
                  idex_en      = 1'b0;
                  exmem_bubble = 1'b1;
                  state_d      = ST_STORE_STALL;
               end
            end

            ST_LOAD_STALL: begin
               // EX holds a bubble here, so BranchTaken cannot be genuine.
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
               if (cnt_q <= 3'd1) begin
                  cnt_d   = 3'd0;
                  state_d = ST_RUN;
               end else begin
                  cnt_d   = cnt_q - 3'd1;
                  state_d = ST_LOAD_STALL;
               end
            end

            ST_MEM_WAIT: begin
               state_d = (cnt_q != 3'd0) ? ST_LOAD_STALL : ST_RUN;
            end

            // STORE_STALL: the stalled store resolves itself this cycle.
            // FLUSH: ID holds a NOP, so no detection is meaningful.
            // Illegal encodings fall through here and recover to RUN.
            default: state_d = ST_RUN;
         endcase
      end

      // Hold the whole pipeline quiet and empty while in reset.
      if (!rst_n) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         exmem_bubble = 1'b1;
         memwb_bubble = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------------
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end
      if (flush_evt) begin
         flush_cnt_d = sat_inc(flush_cnt_q);
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign PC_En         = pc_en;
   assign IF_ID_En      = ifid_en;
   assign ID_EX_En      = idex_en;
   assign EX_MEM_En     = exmem_en;
   assign IF_ID_Flush   = ifid_flush;
   assign ID_EX_Flush   = idex_flush;
   assign EX_MEM_Bubble = exmem_bubble;
   assign MEM_WB_Bubble = memwb_bubble;
   assign State         = state_q;
   assign StallCount    = stall_cnt_q;
   assign FlushCount    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Directed bench for hazard_control_unit. Three instances share all inputs:
//   index 0 : LOAD_LAT=2, CNT_W=16
//   index 1 : LOAD_LAT=3, CNT_W=16
//   index 2 : LOAD_LAT=1, CNT_W=2  (counter saturation, single-cycle load)
// Each scenario resets all instances and checks only the relevant one.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] rn1, rn2, wn;
   logic       uses2, mr, sh, bt, mreq, mrdy;

   logic       pc_en  [3];
   logic       ifid_en[3];
   logic       idex_en[3];
   logic       exm_en [3];
   logic       ifid_fl[3];
   logic       idex_fl[3];
   logic       exm_bb [3];
   logic       mwb_bb [3];
   logic [2:0] st     [3];

   logic [15:0] sc0, fc0, sc1, fc1;
   logic [1:0]  sc2, fc2;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_control_unit #(.LOAD_LAT(2), .CNT_W(16)) u_lat2 (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_RN1(rn1), .IF_ID_RN2(rn2), .IF_ID_UsesRN2(uses2),
      .ID_EX_MR(mr), .ID_EX_WN(wn), .StoreHazard(sh), .BranchTaken(bt),
      .MemReq(mreq), .MemReady(mrdy),
      .PC_En(pc_en[0]), .IF_ID_En(ifid_en[0]), .ID_EX_En(idex_en[0]),
      .EX_MEM_En(exm_en[0]), .IF_ID_Flush(ifid_fl[0]), .ID_EX_Flush(idex_fl[0]),
      .EX_MEM_Bubble(exm_bb[0]), .MEM_WB_Bubble(mwb_bb[0]), .State(st[0]),
      .StallCount(sc0), .FlushCount(fc0)
   );

   hazard_control_unit #(.LOAD_LAT(3), .CNT_W(16)) u_lat3 (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_RN1(rn1), .IF_ID_RN2(rn2), .IF_ID_UsesRN2(uses2),
      .ID_EX_MR(mr), .ID_EX_WN(wn), .StoreHazard(sh), .BranchTaken(bt),
      .MemReq(mreq), .MemReady(mrdy),
      .PC_En(pc_en[1]), .IF_ID_En(ifid_en[1]), .ID_EX_En(idex_en[1]),
      .EX_MEM_En(exm_en[1]), .IF_ID_Flush(ifid_fl[1]), .ID_EX_Flush(idex_fl[1]),
      .EX_MEM_Bubble(exm_bb[1]), .MEM_WB_Bubble(mwb_bb[1]), .State(st[1]),
      .StallCount(sc1), .FlushCount(fc1)
   );

   hazard_control_unit #(.LOAD_LAT(1), .CNT_W(2)) u_cnt2 (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_RN1(rn1), .IF_ID_RN2(rn2), .IF_ID_UsesRN2(uses2),
      .ID_EX_MR(mr), .ID_EX_WN(wn), .StoreHazard(sh), .BranchTaken(bt),
      .MemReq(mreq), .MemReady(mrdy),
      .PC_En(pc_en[2]), .IF_ID_En(ifid_en[2]), .ID_EX_En(idex_en[2]),
      .EX_MEM_En(exm_en[2]), .IF_ID_Flush(ifid_fl[2]), .ID_EX_Flush(idex_fl[2]),
      .EX_MEM_Bubble(exm_bb[2]), .MEM_WB_Bubble(mwb_bb[2]), .State(st[2]),
      .StallCount(sc2), .FlushCount(fc2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      rn1 = 4'd0; rn2 = 4'd0; wn = 4'd0;
      uses2 = 1'b0; mr = 1'b0; sh = 1'b0; bt = 1'b0;
      mreq = 1'b0; mrdy = 1'b0;
   endtask

   // Moves to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Lets Mealy outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      settle();
   endtask

   task automatic set_load_use(input logic [3:0] r);
      mr = 1'b1; wn = r; rn1 = r;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();

      // ---------------- Reset in the middle of a load stall (LOAD_LAT=3) ----
      do_reset();
      set_load_use(4'd5);
      settle();
      chk("rst_pre_pc", pc_en[1], 0);
      next_cycle();
      clear_inputs();
      settle();
      chk("rst_pre_state", st[1], 1);
      rst_n = 1'b0;
      settle();
      chk("rst_state", st[1], 0);
      chk("rst_stall", sc1, 0);
      chk("rst_flush", fc1, 0);
      chk("rst_pc_en", pc_en[1], 0);
      chk("rst_ifid_en", ifid_en[1], 0);
      chk("rst_idex_en", idex_en[1], 0);
      chk("rst_exm_en", exm_en[1], 0);
      chk("rst_ifid_fl", ifid_fl[1], 1);
      chk("rst_idex_fl", idex_fl[1], 1);
      chk("rst_exm_bb", exm_bb[1], 1);
      chk("rst_mwb_bb", mwb_bb[1], 1);
      rst_n = 1'b1;
      settle();
      chk("rel_pc_en", pc_en[1], 1);
      chk("rel_ifid_en", ifid_en[1], 1);
      chk("rel_idex_en", idex_en[1], 1);
      chk("rel_exm_en", exm_en[1], 1);
      chk("rel_ifid_fl", ifid_fl[1], 0);
      chk("rel_mwb_bb", mwb_bb[1], 0);
      next_cycle();
      chk("rel_state_run", st[1], 0);
      chk("rel_pc_en2", pc_en[1], 1);

      // ---------------- Load-use, LOAD_LAT=2 ---------------------------------
      do_reset();
      set_load_use(4'd5);
      settle();
      chk("lu_c0_pc", pc_en[0], 0);
      chk("lu_c0_ifid_en", ifid_en[0], 0);
      chk("lu_c0_idex_fl", idex_fl[0], 1);
      chk("lu_c0_idex_en", idex_en[0], 1);
      next_cycle();
      chk("lu_c1_state", st[0], 1);
      chk("lu_c1_pc", pc_en[0], 0);
      chk("lu_c1_idex_fl", idex_fl[0], 1);
      next_cycle();
      clear_inputs();
      settle();
      chk("lu_c2_state", st[0], 0);
      chk("lu_c2_pc", pc_en[0], 1);
      chk("lu_c2_idex_fl", idex_fl[0], 0);
      chk("lu_c2_stall", sc0, 2);

      // ---------------- Load to r0 / unused RN2 ------------------------------
      do_reset();
      mr = 1'b1; wn = 4'd0; rn1 = 4'd0;
      settle();
      chk("r0_pc", pc_en[0], 1);
      chk("r0_idex_fl", idex_fl[0], 0);
      wn = 4'd7; rn1 = 4'd3; rn2 = 4'd7; uses2 = 1'b0;
      settle();
      chk("rn2_unused_pc", pc_en[0], 1);
      uses2 = 1'b1;
      settle();
      chk("rn2_used_pc", pc_en[0], 0);

      // ---------------- Branch together with load-use -----------------------
      do_reset();
      set_load_use(4'd5);
      bt = 1'b1;
      settle();
      chk("br_ifid_fl", ifid_fl[0], 1);
      chk("br_idex_fl", idex_fl[0], 1);
      chk("br_pc", pc_en[0], 1);
      next_cycle();
      bt = 1'b0;
      settle();
      chk("br_flush_cnt", fc0, 1);
      chk("br_state_flush", st[0], 4);
      chk("br_flush_pc", pc_en[0], 1);
      chk("br_flush_idex_fl", idex_fl[0], 0);
      next_cycle();
      clear_inputs();
      settle();
      chk("br_after_state", st[0], 0);
      chk("br_after_stall", sc0, 0);

      // ---------------- Store-data hazard ------------------------------------
      do_reset();
      sh = 1'b1;
      settle();
      chk("st_pc", pc_en[0], 0);
      chk("st_ifid_en", ifid_en[0], 0);
      chk("st_idex_en", idex_en[0], 0);
      chk("st_exm_en", exm_en[0], 1);
      chk("st_exm_bb", exm_bb[0], 1);
      next_cycle();
      chk("st_hold_state", st[0], 2);
      chk("st_hold_pc", pc_en[0], 1);
      chk("st_hold_exm_bb", exm_bb[0], 0);
      next_cycle();
      sh = 1'b0;
      settle();
      chk("st_after_state", st[0], 0);
      chk("st_after_stall", sc0, 1);

      // ---------------- Memory wait during a LOAD_LAT=3 stall ---------------
      do_reset();
      set_load_use(4'd5);
      settle();
      chk("mw_a_pc", pc_en[1], 0);
      next_cycle();
      clear_inputs();
      settle();
      chk("mw_b_state", st[1], 1);
      chk("mw_b_pc", pc_en[1], 0);
      next_cycle();
      mreq = 1'b1; mrdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("mw_frz_pc", pc_en[1], 0);
         chk("mw_frz_exm_en", exm_en[1], 0);
         chk("mw_frz_mwb_bb", mwb_bb[1], 1);
         chk("mw_frz_state", st[1], (i == 0) ? 1 : 3);
         next_cycle();
      end
      mrdy = 1'b1;
      settle();
      chk("mw_rdy_state", st[1], 3);
      chk("mw_rdy_pc", pc_en[1], 1);
      chk("mw_rdy_mwb_bb", mwb_bb[1], 0);
      next_cycle();
      mreq = 1'b0; mrdy = 1'b0;
      settle();
      chk("mw_resume_state", st[1], 1);
      chk("mw_resume_pc", pc_en[1], 0);
      next_cycle();
      chk("mw_end_state", st[1], 0);
      chk("mw_end_pc", pc_en[1], 1);
      chk("mw_end_stall", sc1, 7);

      // ---------------- Single-cycle load (LOAD_LAT=1) ----------------------
      do_reset();
      set_load_use(4'd9);
      settle();
      chk("l1_pc", pc_en[2], 0);
      next_cycle();
      clear_inputs();
      settle();
      chk("l1_state", st[2], 0);
      chk("l1_pc_after", pc_en[2], 1);

      // ---------------- Counter saturation (CNT_W=2) ------------------------
      do_reset();
      mreq = 1'b1; mrdy = 1'b0;
      for (int i = 0; i < 3; i++) next_cycle();
      chk("sat_stall_3", sc2, 3);
      for (int i = 0; i < 2; i++) next_cycle();
      chk("sat_stall_5", sc2, 3);
      clear_inputs();
      do_reset();
      bt = 1'b1;
      for (int i = 0; i < 10; i++) next_cycle();
      chk("sat_flush", fc2, 3);
      chk("sat_flush_lat3", fc1, 5);
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
